// File: rtl/compalu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : compalu_sequencer
// Purpose  : Buffers R-format instructions in a small FIFO and issues them one
//            at a time to the combinational CompALU. After a programmable
//            settle time it captures the ALU result, pulses a register-file
//            write to rd, and offers the result on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module compalu_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   output logic [31:0]          alu_instr,
   input  logic [31:0]          alu_data,
   input  logic                 alu_zero,
   input  logic                 alu_carry,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rf_wdata,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_data,
   output logic                 res_zero,
   output logic                 res_carry,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] issued_cnt
);

   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_PTR_W + 1;
   localparam int c_EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   localparam logic [c_CNT_W-1:0]  c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_EXEC_W-1:0] c_EXEC_LOAD = c_EXEC_W'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_WAITR = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [31:0]         r_fifo_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_fifo_cnt;
   logic [c_EXEC_W-1:0] r_exec_cnt;

   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_issue;
   logic                w_capture;
   logic                w_exec_dec;
   logic                w_can_capture;

   // in_ready looks only at the registered count, so a pop in the same cycle
   // never frees a slot early and there is no ready->valid combinational path.
   assign in_ready      = (r_fifo_cnt != c_FIFO_FULL);
   assign w_empty       = (r_fifo_cnt == '0);
   assign w_push        = in_valid && in_ready;
   assign w_pop         = w_issue;
   assign w_can_capture = !res_valid || res_ready;
   assign busy          = (r_state != S_IDLE) || !w_empty;

   // FIFO storage: pure data, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= in_instr;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and issue/capture decode
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_exec_dec  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_issue     = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_exec_cnt != '0) begin
               w_exec_dec = 1'b1;
            end else if (w_can_capture) begin
               w_capture   = 1'b1;
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_WAITR;
            end
         end
         S_WAITR: begin
            if (w_can_capture) begin
               w_capture   = 1'b1;
               w_state_nxt = S_WB;
            end
         end
         S_WB: begin
            // The RF write lands on this same edge, so the next instruction
            // loaded here always sees the updated register file.
            if (!w_empty) begin
               w_issue     = 1'b1;
               w_state_nxt = S_EXEC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Issue register, settle counter, result capture and write-back pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_instr  <= '0;
         r_exec_cnt <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_zero   <= 1'b0;
         res_carry  <= 1'b0;
         issued_cnt <= '0;
      end else begin
         rf_we <= 1'b0;
         if (w_issue) begin
            alu_instr  <= r_fifo_mem[r_rd_ptr];
            r_exec_cnt <= c_EXEC_LOAD;
         end else if (w_exec_dec) begin
            r_exec_cnt <= r_exec_cnt - c_EXEC_W'(1);
         end
         if (w_capture) begin
            res_valid  <= 1'b1;
            res_data   <= alu_data;
            res_zero   <= alu_zero;
            res_carry  <= alu_carry;
            rf_waddr   <= alu_instr[15:11];
            rf_wdata   <= alu_data;
            rf_we      <= (alu_instr[15:11] != 5'd0);
            issued_cnt <= issued_cnt + CNT_WIDTH'(1);
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_compalu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_compalu_sequencer
// Purpose  : Self-checking bench for compalu_sequencer. Models CompALU and the
//            register file around the DUT; an in-order architectural model
//            predicts every result and register write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compalu_sequencer;

   localparam int FIFO_DEPTH  = 4;
   localparam int EXEC_CYCLES = 1;
   localparam int CNT_WIDTH   = 16;

   typedef struct packed {
      logic [31:0] data;
      logic        zero;
      logic        carry;
   } res_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [31:0]          in_instr = '0;
   logic [31:0]          alu_instr;
   logic [31:0]          alu_data;
   logic                 alu_zero;
   logic                 alu_carry;
   logic                 rf_we;
   logic [4:0]           rf_waddr;
   logic [31:0]          rf_wdata;
   logic                 res_valid;
   logic                 res_ready = 1'b1;
   logic [31:0]          res_data;
   logic                 res_zero;
   logic                 res_carry;
   logic                 busy;
   logic [CNT_WIDTH-1:0] issued_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_issued = 0;

   res_t exp_res [$];
   wr_t  exp_wr  [$];
   res_t obs_res [$];
   wr_t  obs_wr  [$];
   int   obs_res_rd = 0;
   int   obs_wr_rd  = 0;

   logic [31:0] arch_rf [32];
   logic [31:0] rf [32];
   logic        tb_clr = 1'b1;
   logic        pre_we = 1'b0;
   logic [4:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;

   compalu_sequencer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .EXEC_CYCLES(EXEC_CYCLES),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .alu_instr (alu_instr),
      .alu_data  (alu_data),
      .alu_zero  (alu_zero),
      .alu_carry (alu_carry),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_zero  (res_zero),
      .res_carry (res_carry),
      .busy      (busy),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   // Register file: R0 hardwired to zero, bench preload port when idle
   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (rf_we && rf_waddr != 5'd0) begin
         rf[rf_waddr] <= rf_wdata;
      end else if (pre_we) begin
         rf[pre_addr] <= pre_data;
      end
   end

   // Combinational CompALU: add / sub / and / or selected by funct
   always_comb begin
      alu_a     = rf[alu_instr[25:21]];
      alu_b     = rf[alu_instr[20:16]];
      alu_data  = '0;
      alu_carry = 1'b0;
      case (alu_instr[5:0])
         6'h20:   {alu_carry, alu_data} = {1'b0, alu_a} + {1'b0, alu_b};
         6'h22:   {alu_carry, alu_data} = {1'b0, alu_a} - {1'b0, alu_b};
         6'h24:   alu_data = alu_a & alu_b;
         default: alu_data = alu_a | alu_b;
      endcase
      alu_zero = (alu_data == 32'd0);
   end

   // Record result handshakes and register writes away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid && res_ready) obs_res.push_back({res_data, res_zero, res_carry});
         if (rf_we) obs_wr.push_back({rf_waddr, rf_wdata});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                         input logic [5:0] funct);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural model: executes in order and predicts result and write
   task automatic model_push(input logic [31:0] ins);
      logic [31:0] a, b, d;
      logic        c;
      res_t        r;
      wr_t         w;
      a = arch_rf[ins[25:21]];
      b = arch_rf[ins[20:16]];
      c = 1'b0;
      case (ins[5:0])
         6'h20:   {c, d} = {1'b0, a} + {1'b0, b};
         6'h22:   {c, d} = {1'b0, a} - {1'b0, b};
         6'h24:   d = a & b;
         default: d = a | b;
      endcase
      r.data = d; r.zero = (d == 32'd0); r.carry = c;
      exp_res.push_back(r);
      if (ins[15:11] != 5'd0) begin
         arch_rf[ins[15:11]] = d;
         w.addr = ins[15:11]; w.data = d;
         exp_wr.push_back(w);
      end
      exp_issued++;
   endtask

   task automatic preload(input int addr, input logic [31:0] val);
      pre_we = 1'b1; pre_addr = 5'(addr); pre_data = val;
      arch_rf[addr] = val;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic push(input logic [31:0] ins);
      logic acc;
      int   t;
      acc = 1'b0; t = 0;
      in_valid = 1'b1; in_instr = ins;
      while (!acc && t < 100) begin
         acc = in_ready;
         tick();
         t++;
      end
      in_valid = 1'b0;
      if (acc) model_push(ins);
      else begin
         n_tests++; n_fail++;
         $display("FAIL push_timeout: instr %h not accepted, in_ready=%b required 1", ins, in_ready);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) arch_rf[i] = '0;
      res_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({alu_instr, rf_we, rf_waddr, rf_wdata, res_valid, res_data, res_zero,
           res_carry, issued_cnt, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: alu_instr=%h rf_we=%b res_valid=%b issued=%0d busy=%b, required all 0",
                  alu_instr, rf_we, res_valid, issued_cnt, busy);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      tick();
      #3 rst = 1'b0;
      tb_clr = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      n_tests++;
      if (obs_wr.size() != 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: writes=%0d res_valid=%b busy=%b, required 0 0 0",
                  obs_wr.size(), res_valid, busy);
      end
   endtask

   task automatic test_single_add();
      logic [31:0] ins;
      res_t        er;
      wr_t         ew;
      ins = rtype(1, 2, 3, 6'h20);
      preload(1, 32'd5);
      preload(2, 32'd3);
      push(ins);
      tick();
      n_tests++;
      if (alu_instr !== ins || res_valid !== 1'b0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL add_issue: alu_instr=%h res_valid=%b rf_we=%b, required %h 0 0",
                  alu_instr, res_valid, rf_we, ins);
      end
      tick();
      n_tests++;
      if ({res_valid, res_data, res_zero, rf_we, rf_waddr, rf_wdata} !==
          {1'b1, 32'd8, 1'b0, 1'b1, 5'd3, 32'd8} || issued_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL add_result: valid=%b data=%0d zero=%b we=%b waddr=%0d wdata=%0d cnt=%0d, required 1 8 0 1 3 8 1",
                  res_valid, res_data, res_zero, rf_we, rf_waddr, rf_wdata, issued_cnt);
      end
      tick();
      n_tests++;
      if (rf_we !== 1'b0) begin
         n_fail++; $display("FAIL add_we_pulse: rf_we=%b one cycle later, required 0", rf_we);
      end
      for (int t = 0; t < 100 && ((obs_res.size() - obs_res_rd) < exp_res.size()
                                  || (obs_wr.size() - obs_wr_rd) < exp_wr.size()); t++) tick();
      while (exp_res.size() != 0) begin
         er = exp_res.pop_front(); n_tests++;
         if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
            n_fail++; $display("FAIL add_sb_res: got %h required %h",
                               (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
         end
         obs_res_rd++;
      end
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front(); n_tests++;
         if (obs_wr_rd >= obs_wr.size() || obs_wr[obs_wr_rd] !== ew) begin
            n_fail++; $display("FAIL add_sb_wr: got %h required %h",
                               (obs_wr_rd < obs_wr.size()) ? obs_wr[obs_wr_rd] : '0, ew);
         end
         obs_wr_rd++;
      end
   endtask

   task automatic test_rd0_carry();
      res_t er;
      int   t;
      preload(5, 32'hFFFF_FFFF);
      preload(6, 32'd1);
      push(rtype(5, 6, 0, 6'h20));
      t = 0;
      while (res_valid !== 1'b1 && t < 50) begin tick(); t++; end
      n_tests++;
      if ({res_valid, res_data, res_zero, res_carry, rf_we} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rd0_result: valid=%b data=%h zero=%b carry=%b we=%b, required 1 0 1 1 0",
                  res_valid, res_data, res_zero, res_carry, rf_we);
      end
      for (int i = 0; i < 5; i++) tick();
      er = exp_res.pop_front(); n_tests++;
      if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
         n_fail++; $display("FAIL rd0_sb_res: got %h required %h",
                            (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
      end
      obs_res_rd++;
      n_tests++;
      if (obs_wr.size() != obs_wr_rd || rf[0] !== 32'd0) begin
         n_fail++; $display("FAIL rd0_no_write: extra writes=%0d R0=%h, required 0 0",
                            obs_wr.size() - obs_wr_rd, rf[0]);
      end
   endtask

   task automatic test_dependent_chain();
      logic [31:0] i1, i2;
      res_t        er;
      wr_t         ew;
      i1 = rtype(1, 2, 3, 6'h20);
      i2 = rtype(3, 3, 4, 6'h20);
      push(i1);
      push(i2);
      n_tests++;
      if (alu_instr !== i1) begin
         n_fail++; $display("FAIL chain_issue1: alu_instr=%h required %h", alu_instr, i1);
      end
      tick();
      n_tests++;
      if (alu_instr !== i1) begin
         n_fail++; $display("FAIL chain_spacing: alu_instr=%h one cycle after issue, required %h", alu_instr, i1);
      end
      tick();
      n_tests++;
      if (alu_instr !== i2) begin
         n_fail++; $display("FAIL chain_issue2: alu_instr=%h two cycles after issue, required %h", alu_instr, i2);
      end
      tick();
      n_tests++;
      if ({res_valid, res_data, rf_we, rf_waddr, rf_wdata} !== {1'b1, 32'd16, 1'b1, 5'd4, 32'd16}) begin
         n_fail++;
         $display("FAIL chain_result: valid=%b data=%0d we=%b waddr=%0d wdata=%0d, required 1 16 1 4 16",
                  res_valid, res_data, rf_we, rf_waddr, rf_wdata);
      end
      for (int t = 0; t < 100 && ((obs_res.size() - obs_res_rd) < exp_res.size()
                                  || (obs_wr.size() - obs_wr_rd) < exp_wr.size()); t++) tick();
      while (exp_res.size() != 0) begin
         er = exp_res.pop_front(); n_tests++;
         if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
            n_fail++; $display("FAIL chain_sb_res: got %h required %h",
                               (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
         end
         obs_res_rd++;
      end
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front(); n_tests++;
         if (obs_wr_rd >= obs_wr.size() || obs_wr[obs_wr_rd] !== ew) begin
            n_fail++; $display("FAIL chain_sb_wr: got %h required %h",
                               (obs_wr_rd < obs_wr.size()) ? obs_wr[obs_wr_rd] : '0, ew);
         end
         obs_wr_rd++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] i2;
      res_t        er;
      wr_t         ew;
      int          unstable;
      i2 = rtype(1, 2, 8, 6'h22);
      res_ready = 1'b0;
      push(rtype(1, 2, 7, 6'h20));
      push(i2);
      push(rtype(7, 8, 9, 6'h20));
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if ({res_valid, res_data, alu_instr, busy, in_ready} !== {1'b1, 32'd8, i2, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_hold: valid=%b data=%0d alu_instr=%h busy=%b in_ready=%b, required 1 8 %h 1 1",
                  res_valid, res_data, alu_instr, busy, in_ready, i2);
      end
      unstable = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_data !== 32'd8 || alu_instr !== i2) unstable++;
      end
      n_tests++;
      if (unstable != 0) begin
         n_fail++; $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable);
      end
      res_ready = 1'b1;
      for (int t = 0; t < 100 && ((obs_res.size() - obs_res_rd) < exp_res.size()
                                  || (obs_wr.size() - obs_wr_rd) < exp_wr.size()); t++) tick();
      while (exp_res.size() != 0) begin
         er = exp_res.pop_front(); n_tests++;
         if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
            n_fail++; $display("FAIL bp_sb_res: got %h required %h",
                               (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
         end
         obs_res_rd++;
      end
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front(); n_tests++;
         if (obs_wr_rd >= obs_wr.size() || obs_wr[obs_wr_rd] !== ew) begin
            n_fail++; $display("FAIL bp_sb_wr: got %h required %h",
                               (obs_wr_rd < obs_wr.size()) ? obs_wr[obs_wr_rd] : '0, ew);
         end
         obs_wr_rd++;
      end
      n_tests++;
      if (issued_cnt !== 16'(exp_issued)) begin
         n_fail++; $display("FAIL bp_issued_cnt: got %0d required %0d", issued_cnt, exp_issued);
      end
   endtask

   task automatic test_fifo_full();
      logic [31:0] i7;
      logic        acc;
      res_t        er;
      wr_t         ew;
      int          ready_seen;
      i7 = rtype(3, 4, 17, 6'h24);
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) push(rtype(k + 1, 2, 10 + k, (k % 2 == 0) ? 6'h20 : 6'h22));
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_early: in_ready=%b with 3 queued, required 1", in_ready);
      end
      push(rtype(6, 2, 15, 6'h20));
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_ready: in_ready=%b with 4 queued, required 0", in_ready);
      end
      in_valid = 1'b1; in_instr = i7;
      ready_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (in_ready !== 1'b0) ready_seen++;
      end
      n_tests++;
      if (ready_seen != 0) begin
         n_fail++; $display("FAIL full_held: in_ready high %0d cycles while full, required 0", ready_seen);
      end
      res_ready = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      n_tests++;
      if (!acc) begin
         n_fail++; $display("FAIL full_release: held instr accepted=%b, required 1", acc);
      end else model_push(i7);
      for (int t = 0; t < 200 && ((obs_res.size() - obs_res_rd) < exp_res.size()
                                  || (obs_wr.size() - obs_wr_rd) < exp_wr.size()); t++) tick();
      while (exp_res.size() != 0) begin
         er = exp_res.pop_front(); n_tests++;
         if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
            n_fail++; $display("FAIL full_sb_res: got %h required %h",
                               (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
         end
         obs_res_rd++;
      end
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front(); n_tests++;
         if (obs_wr_rd >= obs_wr.size() || obs_wr[obs_wr_rd] !== ew) begin
            n_fail++; $display("FAIL full_sb_wr: got %h required %h",
                               (obs_wr_rd < obs_wr.size()) ? obs_wr[obs_wr_rd] : '0, ew);
         end
         obs_wr_rd++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] list [10];
      logic [5:0]  fn;
      logic        acc;
      int          idx;
      res_t        er;
      wr_t         ew;
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 2))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            default: fn = 6'h24;
         endcase
         list[i] = rtype($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(0, 15), fn);
      end
      idx = 0;
      for (int t = 0; t < 500 && idx < 10; t++) begin
         res_ready = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = list[idx];
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            model_push(list[idx]);
            idx++;
         end
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      for (int t = 0; t < 300 && ((obs_res.size() - obs_res_rd) < exp_res.size()
                                  || (obs_wr.size() - obs_wr_rd) < exp_wr.size()); t++) tick();
      n_tests++;
      if (idx != 10) begin
         n_fail++; $display("FAIL b2b_accept: accepted %0d required 10", idx);
      end
      while (exp_res.size() != 0) begin
         er = exp_res.pop_front(); n_tests++;
         if (obs_res_rd >= obs_res.size() || obs_res[obs_res_rd] !== er) begin
            n_fail++; $display("FAIL b2b_sb_res: got %h required %h",
                               (obs_res_rd < obs_res.size()) ? obs_res[obs_res_rd] : '0, er);
         end
         obs_res_rd++;
      end
      while (exp_wr.size() != 0) begin
         ew = exp_wr.pop_front(); n_tests++;
         if (obs_wr_rd >= obs_wr.size() || obs_wr[obs_wr_rd] !== ew) begin
            n_fail++; $display("FAIL b2b_sb_wr: got %h required %h",
                               (obs_wr_rd < obs_wr.size()) ? obs_wr[obs_wr_rd] : '0, ew);
         end
         obs_wr_rd++;
      end
      n_tests++;
      if (issued_cnt !== 16'(exp_issued) || obs_wr.size() != obs_wr_rd || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_final: issued=%0d extra_writes=%0d busy=%b, required %0d 0 0",
                            issued_cnt, obs_wr.size() - obs_wr_rd, busy, exp_issued);
      end
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b0;
      push(rtype(1, 2, 20, 6'h20));
      push(rtype(1, 2, 21, 6'h22));
      push(rtype(1, 2, 22, 6'h20));
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if (res_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_preload: res_valid=%b busy=%b before reset, required 1 1", res_valid, busy);
      end
      #3 rst = 1'b1;
      #1;
      n_tests++;
      if ({alu_instr, rf_we, rf_waddr, rf_wdata, res_valid, res_data, res_zero,
           res_carry, issued_cnt, busy} !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: alu_instr=%h we=%b valid=%b issued=%0d busy=%b in_ready=%b, required 0 0 0 0 0 1",
                  alu_instr, rf_we, res_valid, issued_cnt, busy, in_ready);
      end
      exp_res.delete();
      exp_wr.delete();
      obs_res_rd = obs_res.size();
      obs_wr_rd  = obs_wr.size();
      tick();
      #3 rst = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      n_tests++;
      if (obs_wr.size() != obs_wr_rd || obs_res.size() != obs_res_rd || res_valid !== 1'b0
          || busy !== 1'b0 || issued_cnt !== '0) begin
         n_fail++;
         $display("FAIL mid_quiet: writes=%0d results=%0d valid=%b busy=%b issued=%0d, required all 0",
                  obs_wr.size() - obs_wr_rd, obs_res.size() - obs_res_rd, res_valid, busy, issued_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_rd0_carry();
      test_dependent_chain();
      test_backpressure();
      test_fifo_full();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
